// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared state encoding and counter width helper for the key front end
package key_event_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESS_DB = 3'd1,
      HELD     = 3'd2,
      LONG     = 3'd3,
      REL_DB   = 3'd4
   } key_fsm_e;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_event_chan.sv
// rtl/key_event_chan.sv - one key channel: 2-FF sync, debounce FSM, press/long/release strobes
// Auto-repeat in LONG is built only when KEY_REPEAT_EN is defined.
module key_event_chan
   import key_event_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 300_000,
   parameter int LONG_CYC     = 50_000_000,
   parameter int REPEAT_CYC   = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n_i,
   output logic key_state_o,
   output logic press_pulse_o,
   output logic long_pulse_o,
   output logic release_pulse_o
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

   logic             sync1_q, sync2_q;
   key_fsm_e         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             long_done_q, long_done_d;
   logic             key_state_q, key_state_d;
   logic             press_q, press_d;
   logic             long_q, long_d;
   logic             release_q, release_d;
   logic             rep_hit;
   logic             key_s;

   assign key_s = sync2_q;

   always_comb begin
      state_d     = state_q;
      long_done_d = long_done_q;
      key_state_d = key_state_q;
      press_d     = 1'b0;
      long_d      = 1'b0;
      release_d   = 1'b0;
      rep_hit     = 1'b0;
      case (state_q)
         IDLE: if (!key_s) state_d = PRESS_DB;
         PRESS_DB: begin
            if (key_s) begin
               state_d = IDLE;
            end else if (cnt_q == DB_LAST) begin
               state_d     = HELD;
               press_d     = 1'b1;
               key_state_d = 1'b1;
            end
         end
         HELD: begin
            if (key_s) begin
               state_d = REL_DB;
            end else if (cnt_q == LONG_LAST) begin
               state_d     = LONG;
               long_d      = 1'b1;
               long_done_d = 1'b1;
            end
         end
         LONG: begin
            if (key_s) begin
               state_d = REL_DB;
`ifdef KEY_REPEAT_EN
            end else if (cnt_q == REP_LAST) begin
               press_d = 1'b1;
               rep_hit = 1'b1;
`endif
            end
         end
         REL_DB: begin
            // a bounce back low resumes the hold; long_done picks which hold state
            if (!key_s) begin
               state_d = long_done_q ? LONG : HELD;
            end else if (cnt_q == DB_LAST) begin
               state_d     = IDLE;
               release_d   = 1'b1;
               key_state_d = 1'b0;
               long_done_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            key_state_d = 1'b0;
            long_done_d = 1'b0;
         end
      endcase

      if (state_d != state_q || rep_hit) cnt_d = '0;
      else if (cnt_q != CNT_MAX)         cnt_d = cnt_q + 1'b1;
      else                               cnt_d = cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         long_done_q <= 1'b0;
         key_state_q <= 1'b0;
         press_q     <= 1'b0;
         long_q      <= 1'b0;
         release_q   <= 1'b0;
      end else begin
         sync1_q     <= key_n_i;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         long_done_q <= long_done_d;
         key_state_q <= key_state_d;
         press_q     <= press_d;
         long_q      <= long_d;
         release_q   <= release_d;
      end
   end

   assign key_state_o     = key_state_q;
   assign press_pulse_o   = press_q;
   assign long_pulse_o    = long_q;
   assign release_pulse_o = release_q;

endmodule

// File: rtl/key_event_multi.sv
// rtl/key_event_multi.sv - NUM_KEYS independent debounced key channels with event strobes
// Auto-repeat is enabled per channel by defining KEY_REPEAT_EN.
module key_event_multi
   import key_event_pkg::*;
#(
   parameter int NUM_KEYS     = 4,
   parameter int DEBOUNCE_CYC = 300_000,
   parameter int LONG_CYC     = 50_000_000,
   parameter int REPEAT_CYC   = 10_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] long_pulse,
   output logic [NUM_KEYS-1:0] release_pulse
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
      key_event_chan #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .LONG_CYC     (LONG_CYC),
         .REPEAT_CYC   (REPEAT_CYC)
      ) u_chan (
         .clk             (clk),
         .rst             (rst),
         .key_n_i         (key_n[g]),
         .key_state_o     (key_state[g]),
         .press_pulse_o   (press_pulse[g]),
         .long_pulse_o    (long_pulse[g]),
         .release_pulse_o (release_pulse[g])
      );
   end

endmodule

// File: tb/tb_key_event_multi.sv
// tb/tb_key_event_multi.sv - self-checking bench for key_event_multi (honours KEY_REPEAT_EN)
module tb_key_event_multi;

   localparam int NK = 4;
   localparam int DB = 8;
   localparam int LG = 40;
   localparam int RP = 16;
`ifdef KEY_REPEAT_EN
   localparam int REP_ON = 1;
`else
   localparam int REP_ON = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [NK-1:0] key_n;
   logic [NK-1:0] key_state, press_pulse, long_pulse, release_pulse;

   always #5 clk = ~clk;

   key_event_multi #(
      .NUM_KEYS     (NK),
      .DEBOUNCE_CYC (DB),
      .LONG_CYC     (LG),
      .REPEAT_CYC   (RP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .key_n         (key_n),
      .key_state     (key_state),
      .press_pulse   (press_pulse),
      .long_pulse    (long_pulse),
      .release_pulse (release_pulse)
   );

   int errors = 0;
   int checks = 0;
   int edge_n = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Model: debounced level from run lengths of the 2-cycle-delayed pin, hold timer in edges
   logic [NK-1:0] m_s1, m_s2, m_pressed, m_press, m_long, m_rel;
   int run0[NK], run1[NK], tmr[NK];
   bit longd[NK];

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_s1 = '1; m_s2 = '1;
            m_pressed = '0; m_press = '0; m_long = '0; m_rel = '0;
            for (int k = 0; k < NK; k++) begin
               run0[k] = 0; run1[k] = 0; tmr[k] = 0; longd[k] = 0;
            end
         end else begin
            for (int k = 0; k < NK; k++) begin
               logic v;
               v = m_s2[k];
               m_press[k] = 1'b0; m_long[k] = 1'b0; m_rel[k] = 1'b0;
               if (!m_pressed[k]) begin
                  run0[k] = v ? 0 : run0[k] + 1;
                  if (run0[k] == DB + 1) begin
                     m_press[k] = 1'b1; m_pressed[k] = 1'b1;
                     run0[k] = 0; run1[k] = 0; tmr[k] = 0; longd[k] = 0;
                  end
               end else if (v) begin
                  run1[k]++;
                  if (run1[k] == DB + 1) begin
                     m_rel[k] = 1'b1; m_pressed[k] = 1'b0; run0[k] = 0; run1[k] = 0;
                  end
               end else if (run1[k] != 0) begin
                  run1[k] = 0; tmr[k] = 0;
               end else begin
                  tmr[k]++;
                  if (!longd[k] && tmr[k] == LG) begin
                     m_long[k] = 1'b1; longd[k] = 1; tmr[k] = 0;
                  end else if (REP_ON != 0 && longd[k] && tmr[k] == RP) begin
                     m_press[k] = 1'b1; tmr[k] = 0;
                  end
               end
            end
            m_s2 = m_s1;
            m_s1 = key_n;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   int n_press[NK], n_long[NK], n_rel[NK], e_press[NK], e_long[NK], e_rel[NK];
   logic [NK-1:0] seen_state;
   int all4_edge;

   task automatic clear_logs();
      for (int k = 0; k < NK; k++) begin
         n_press[k] = 0; n_long[k] = 0; n_rel[k] = 0;
         e_press[k] = -1; e_long[k] = -1; e_rel[k] = -1;
      end
      seen_state = '0;
      all4_edge  = -1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         check("key_state", 32'(key_state), 32'(m_pressed));
         check("press_pulse", 32'(press_pulse), 32'(m_press));
         check("long_pulse", 32'(long_pulse), 32'(m_long));
         check("release_pulse", 32'(release_pulse), 32'(m_rel));
         seen_state |= key_state;
         if (press_pulse == 4'b1111) all4_edge = edge_n;
         for (int k = 0; k < NK; k++) begin
            if (press_pulse[k])   begin n_press[k]++; e_press[k] = edge_n; end
            if (long_pulse[k])    begin n_long[k]++;  e_long[k]  = edge_n; end
            if (release_pulse[k]) begin n_rel[k]++;   e_rel[k]   = edge_n; end
         end
      end
   end

   int t0, t1;

   initial begin
      rst = 1'b1;
      key_n = '1;
      clear_logs();
      repeat (3) @(negedge clk);
      check("reset_outputs", {16'd0, key_state, press_pulse, long_pulse, release_pulse}, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // key0 short press of 30 cycles; key1 5-cycle glitch
      clear_logs();
      t0 = edge_n + 1;
      key_n[0] = 1'b0; key_n[1] = 1'b0;
      repeat (5) @(negedge clk);
      key_n[1] = 1'b1;
      repeat (25) @(negedge clk);
      key_n[0] = 1'b1;
      t1 = edge_n + 1;
      repeat (30) @(negedge clk);
      check("k0_press_lat", 32'(e_press[0] - t0), 32'd10);
      check("k0_press_cnt", 32'(n_press[0]), 32'd1);
      check("k0_rel_lat", 32'(e_rel[0] - t1), 32'd10);
      check("k0_no_long", 32'(n_long[0]), 32'd0);
      check("k1_no_events", 32'(n_press[1] + n_long[1] + n_rel[1]), 32'd0);
      check("k1_state_low", 32'(seen_state[1]), 32'd0);

      // key2 long hold of 100 cycles; key3 held with a 3-cycle release glitch
      clear_logs();
      t0 = edge_n + 1;
      key_n[3:2] = 2'b00;
      repeat (20) @(negedge clk);
      key_n[3] = 1'b1;
      repeat (3) @(negedge clk);
      key_n[3] = 1'b0;
      repeat (77) @(negedge clk);
      key_n[3:2] = 2'b11;
      t1 = edge_n + 1;
      repeat (30) @(negedge clk);
      check("k2_long_lat", 32'(e_long[2] - t0), 32'd50);
      check("k2_press_cnt", 32'(n_press[2]), (REP_ON != 0) ? 32'd4 : 32'd1);
      check("k2_last_press", 32'(e_press[2] - t0), (REP_ON != 0) ? 32'd98 : 32'd10);
      check("k2_rel_lat", 32'(e_rel[2] - t1), 32'd10);
      check("k3_long_lat", 32'(e_long[3] - t0), 32'd65);
      check("k3_single_rel", 32'(n_rel[3]), 32'd1);
      check("k3_rel_lat", 32'(e_rel[3] - t1), 32'd10);

      // reset during press debounce with the key still held
      clear_logs();
      key_n[0] = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midreset_outputs", {16'd0, key_state, press_pulse, long_pulse, release_pulse}, 32'd0);
      rst = 1'b0;
      t1 = edge_n + 1;
      repeat (20) @(negedge clk);
      check("rst_press_lat", 32'(e_press[0] - t1), 32'd10);
      check("rst_press_cnt", 32'(n_press[0]), 32'd1);
      key_n[0] = 1'b1;
      repeat (20) @(negedge clk);

      // all keys pressed on the same edge
      clear_logs();
      t0 = edge_n + 1;
      key_n = '0;
      repeat (15) @(negedge clk);
      check("all4_press_lat", 32'(all4_edge - t0), 32'd10);
      key_n = '1;
      repeat (20) @(negedge clk);

      // key0 bounce after long press returns to LONG without a second long
      clear_logs();
      t0 = edge_n + 1;
      key_n[0] = 1'b0;
      repeat (55) @(negedge clk);
      key_n[0] = 1'b1;
      repeat (3) @(negedge clk);
      key_n[0] = 1'b0;
      repeat (12) @(negedge clk);
      key_n[0] = 1'b1;
      t1 = edge_n + 1;
      repeat (20) @(negedge clk);
      check("k0_long_once", 32'(n_long[0]), 32'd1);
      check("k0_bounce_press", 32'(n_press[0]), 32'd1);
      check("k0_bounce_rel", 32'(e_rel[0] - t1), 32'd10);
      check("k0_bounce_relcnt", 32'(n_rel[0]), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
